// File: rtl/pipe_ctrl_pkg.sv
// Shared defaults and helpers for the pipeline handshake controller.
// The flush-stage clamp lives here so every consumer agrees on out-of-range indices.
package pipe_ctrl_pkg;

    localparam int STAGES_DEF = 5;
    localparam int BUS_W_DEF  = 180;
    localparam int CNT_W_DEF  = 32;
    localparam int FLUSH_W    = 3;

    // Indices beyond the last stage flush everything above fetch.
    function automatic logic [FLUSH_W-1:0] clamp_flush(input logic [FLUSH_W-1:0] fs,
                                                       input int stages);
        if (int'(fs) >= stages) return FLUSH_W'(stages - 1);
        return fs;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stage_reg.sv
// One inter-stage register: valid bit plus the bus captured on handover.
// Flush clear wins over a concurrent load of the valid bit; the bus still captures.
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int BUS_W = BUS_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             upd,
    input  logic             in_valid,
    input  logic             clr,
    input  logic [BUS_W-1:0] bus_in,
    output logic             valid,
    output logic [BUS_W-1:0] bus_out
);

    logic             valid_q, valid_d;
    logic [BUS_W-1:0] bus_q, bus_d;

    always_comb begin
        valid_d = valid_q;
        bus_d   = bus_q;
        if (upd) valid_d = in_valid;
        if (clr) valid_d = 1'b0;
        if (upd && in_valid) bus_d = bus_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            bus_q   <= '0;
        end else begin
            valid_q <= valid_d;
            bus_q   <= bus_d;
        end
    end

    assign valid   = valid_q;
    assign bus_out = bus_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline handshake controller: backpressure chain, flush, stage registers
// and saturating stall/flush event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int BUS_W  = BUS_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [STAGES-1:0]           stage_over,
    input  logic [STAGES*BUS_W-1:0]     stage_bus,
    input  logic                        flush_req,
    input  logic [2:0]                  flush_stage,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES-1:0]           allow_in,
    output logic                        next_fetch,
    output logic [(STAGES-1)*BUS_W-1:0] bus_r,
    output logic [3:0]                  occupancy,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    logic [STAGES-1:0] eff_over;
    logic [STAGES-1:1] flush_clr;
    logic [2:0]        flush_k;
    logic              valid0_q, valid0_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              unused_last_bus;

    // Writeback has no consumer, so its outgoing bus slice is dropped.
    assign unused_last_bus = ^stage_bus[STAGES*BUS_W-1 -: BUS_W];

    // Backpressure ripples from writeback toward fetch.
    always_comb begin
        eff_over = stage_valid & stage_over;
        allow_in = '0;
        allow_in[STAGES-1] = !stage_valid[STAGES-1] || eff_over[STAGES-1];
        for (int i = STAGES - 2; i >= 1; i--)
            allow_in[i] = !stage_valid[i] || (eff_over[i] && allow_in[i+1]);
        allow_in[0] = (eff_over[0] && allow_in[1]) || flush_req;
    end

    always_comb begin
        flush_k   = clamp_flush(flush_stage, STAGES);
        flush_clr = '0;
        for (int i = 1; i < STAGES; i++)
            flush_clr[i] = flush_req && (i <= int'(flush_k));
    end

    always_comb begin
        valid0_d    = 1'b1;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stage_valid[0] && !allow_in[0] && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_req && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid0_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid0_q    <= valid0_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        pipe_stage_reg #(.BUS_W(BUS_W)) u_stage (
            .clk      (clk),
            .reset    (reset),
            .upd      (allow_in[g]),
            .in_valid (eff_over[g-1]),
            .clr      (flush_clr[g]),
            .bus_in   (stage_bus[(g-1)*BUS_W +: BUS_W]),
            .valid    (stage_valid[g]),
            .bus_out  (bus_r[(g-1)*BUS_W +: BUS_W])
        );
    end

    assign stage_valid[0] = valid0_q;
    assign next_fetch     = allow_in[0];
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++)
            occupancy = occupancy + {3'b000, stage_valid[i]};
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: vector table, directed stall/reset/saturation sequences,
// and randomized traffic against a cycle-level occupancy model.
module tb_pipe_ctrl;

    localparam int ST = 5;
    localparam int BW = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [ST-1:0]          stage_over;
    logic [ST*BW-1:0]       stage_bus;
    logic                   flush_req;
    logic [2:0]             flush_stage;
    logic [ST-1:0]          stage_valid, allow_in;
    logic                   next_fetch;
    logic [(ST-1)*BW-1:0]   bus_r;
    logic [3:0]             occupancy;
    logic [31:0]            stall_cnt, flush_cnt;
    logic [ST-1:0]          unused_s_valid, unused_s_allow;
    logic                   unused_s_nf;
    logic [(ST-1)*BW-1:0]   unused_s_bus;
    logic [3:0]             unused_s_occ;
    logic [2:0]             s_stall, s_flush;

    pipe_ctrl #(.STAGES(ST), .BUS_W(BW), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stage_over(stage_over), .stage_bus(stage_bus),
        .flush_req(flush_req), .flush_stage(flush_stage), .stage_valid(stage_valid),
        .allow_in(allow_in), .next_fetch(next_fetch), .bus_r(bus_r),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.STAGES(ST), .BUS_W(BW), .CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .stage_over(stage_over), .stage_bus(stage_bus),
        .flush_req(flush_req), .flush_stage(flush_stage), .stage_valid(unused_s_valid),
        .allow_in(unused_s_allow), .next_fetch(unused_s_nf), .bus_r(unused_s_bus),
        .occupancy(unused_s_occ), .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Model: which slots hold an entry, what each register captured, event tallies.
    bit          m_v[ST];
    bit          m_allow[ST];
    logic [7:0]  m_b[ST-1];
    longint      m_stall, m_flush;
    int          m_stall3, m_flush3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ST; i++) m_v[i] = 0;
        for (int i = 0; i < ST - 1; i++) m_b[i] = '0;
        m_stall = 0; m_flush = 0; m_stall3 = 0; m_flush3 = 0;
    endtask

    // A slot has room if empty, or its occupant finishes and can move on.
    task automatic model_comb();
        for (int i = ST - 1; i >= 0; i--) begin
            bit leaving;
            bit room_ahead;
            leaving    = m_v[i] && stage_over[i];
            room_ahead = (i == ST - 1) ? 1'b1 : m_allow[(i == ST - 1) ? i : i + 1];
            if (i == 0) m_allow[i] = (leaving && room_ahead) || flush_req;
            else        m_allow[i] = !m_v[i] || (leaving && room_ahead);
        end
    endtask

    task automatic model_step();
        int k;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_v[0] && !m_allow[0]) begin
            if (m_stall < 64'hFFFF_FFFF) m_stall++;
            if (m_stall3 < 7) m_stall3++;
        end
        if (flush_req) begin
            if (m_flush < 64'hFFFF_FFFF) m_flush++;
            if (m_flush3 < 7) m_flush3++;
        end
        k = (int'(flush_stage) >= ST) ? ST - 1 : int'(flush_stage);
        for (int i = ST - 1; i >= 1; i--) begin
            bit moved;
            moved = m_v[i-1] && stage_over[i-1] && m_allow[i];
            if (moved) m_b[i-1] = stage_bus[(i-1)*BW +: BW];
            if (m_allow[i]) m_v[i] = m_v[i-1] && stage_over[i-1];
            if (flush_req && i <= k) m_v[i] = 0;
        end
        m_v[0] = 1;
    endtask

    task automatic check_all();
        logic [ST-1:0]        pv, pa;
        logic [(ST-1)*BW-1:0] pb;
        int                   cnt;
        cnt = 0;
        for (int i = 0; i < ST; i++) begin
            pv[i] = m_v[i];
            pa[i] = m_allow[i];
            cnt += int'(m_v[i]);
        end
        for (int i = 0; i < ST - 1; i++) pb[i*BW +: BW] = m_b[i];
        chk("stage_valid", 64'(stage_valid), 64'(pv));
        chk("allow_in", 64'(allow_in), 64'(pa));
        chk("next_fetch", 64'(next_fetch), 64'(pa[0]));
        chk("occupancy", 64'(occupancy), 64'(cnt));
        chk("bus_r", 64'(bus_r), 64'(pb));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        chk("stall_cnt3", 64'(s_stall), 64'(m_stall3));
        chk("flush_cnt3", 64'(s_flush), 64'(m_flush3));
    endtask

    task automatic tick();
        @(negedge clk);
        model_comb();
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [ST-1:0]    over;
        logic             fl;
        logic [2:0]       fs;
        logic [ST*BW-1:0] bus;
        logic [ST-1:0]    exp_allow;
        logic [ST-1:0]    exp_valid;
        int               exp_stall;
        int               exp_flush;
        bit               bchk;
    } vec_t;

    function automatic vec_t mk(logic [ST-1:0] over, logic fl, logic [2:0] fs,
                                logic [ST*BW-1:0] bus, logic [ST-1:0] ea,
                                logic [ST-1:0] ev, int es, int ef, bit bchk);
        vec_t v;
        v.over = over; v.fl = fl; v.fs = fs; v.bus = bus; v.exp_allow = ea;
        v.exp_valid = ev; v.exp_stall = es; v.exp_flush = ef; v.bchk = bchk;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(5'b11111, 0, 3'd0, 40'h0101010101, 5'b11110, 5'b00001, 0, 0, 0);
        tbl[1]  = mk(5'b11111, 0, 3'd0, 40'h1212121212, 5'b11111, 5'b00011, 0, 0, 0);
        tbl[2]  = mk(5'b11111, 0, 3'd0, 40'h2323232323, 5'b11111, 5'b00111, 0, 0, 0);
        tbl[3]  = mk(5'b11111, 0, 3'd0, 40'h3434343434, 5'b11111, 5'b01111, 0, 0, 0);
        tbl[4]  = mk(5'b11111, 0, 3'd0, 40'h4545454545, 5'b11111, 5'b11111, 0, 0, 0);
        tbl[5]  = mk(5'b11111, 1, 3'd2, 40'h0000A50000, 5'b11111, 5'b11001, 0, 1, 1);
        tbl[6]  = mk(5'b11111, 0, 3'd0, 40'h5656565656, 5'b11111, 5'b10011, 0, 1, 0);
        tbl[7]  = mk(5'b11111, 0, 3'd0, 40'h6767676767, 5'b11111, 5'b00111, 0, 1, 0);
        tbl[8]  = mk(5'b11111, 1, 3'd7, 40'h7878787878, 5'b11111, 5'b00001, 0, 2, 0);
        tbl[9]  = mk(5'b00000, 0, 3'd0, 40'h8989898989, 5'b11110, 5'b00001, 1, 2, 0);
        tbl[10] = mk(5'b00000, 0, 3'd0, 40'h9A9A9A9A9A, 5'b11110, 5'b00001, 2, 2, 0);
        tbl[11] = mk(5'b00000, 1, 3'd0, 40'hABABABABAB, 5'b11111, 5'b00001, 2, 3, 0);

        reset = 1'b1; stage_over = '0; stage_bus = '0; flush_req = 1'b0; flush_stage = '0;
        @(posedge clk); #1;
        model_reset();
        tick();
        chk("reset valid", 64'(stage_valid), 64'(0));
        chk("reset stall", 64'(stall_cnt), 64'(0));

        // Vector table: fill, flush k=2, drain, clamped flush, stall, flush k=0.
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            stage_over = tbl[i].over; flush_req = tbl[i].fl;
            flush_stage = tbl[i].fs; stage_bus = tbl[i].bus;
            #1;
            chk($sformatf("row%0d allow", i), 64'(allow_in), 64'(tbl[i].exp_allow));
            tick();
            chk($sformatf("row%0d valid", i), 64'(stage_valid), 64'(tbl[i].exp_valid));
            chk($sformatf("row%0d stall", i), 64'(stall_cnt), 64'(tbl[i].exp_stall));
            chk($sformatf("row%0d flush", i), 64'(flush_cnt), 64'(tbl[i].exp_flush));
            if (tbl[i].bchk) chk($sformatf("row%0d bus2", i), 64'(bus_r[23:16]), 64'h0A5);
        end
        flush_req = 1'b0; flush_stage = '0;

        // Stall at stage 3 on a full pipe, then reset mid-operation.
        reset = 1'b1; stage_over = '1; tick(); reset = 1'b0;
        repeat (5) tick();
        chk("full valid", 64'(stage_valid), 64'(5'b11111));
        stage_bus = 40'h003C000000; tick();
        chk("bus3 load", 64'(bus_r[31:24]), 64'h3C);
        stage_over = 5'b10111;
        for (int c = 0; c < 7; c++) begin
            stage_bus = {$urandom, 8'($urandom)};
            #1;
            chk($sformatf("stall%0d allow", c), 64'(allow_in[3:0]), 64'(0));
            tick();
            chk($sformatf("stall%0d bus3", c), 64'(bus_r[31:24]), 64'h3C);
            if (c == 3) chk("stall_cnt 4", 64'(stall_cnt), 64'(4));
        end
        chk("stall_cnt 7", 64'(stall_cnt), 64'(7));
        reset = 1'b1; flush_req = 1'b1; flush_stage = 3'd2; stage_over = '1; tick();
        reset = 1'b0; flush_req = 1'b0;
        chk("mid reset valid", 64'(stage_valid), 64'(0));
        chk("mid reset bus", 64'(bus_r), 64'(0));
        chk("mid reset stall", 64'(stall_cnt), 64'(0));
        chk("mid reset flush", 64'(flush_cnt), 64'(0));

        // Narrow counter saturation.
        repeat (5) tick();
        stage_over = 5'b10111;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 9) chk("sat3 at 10", 64'(s_stall), 64'(7));
        end
        chk("sat3 hold", 64'(s_stall), 64'(7));
        chk("wide stall 12", 64'(stall_cnt), 64'(12));

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            stage_over  = ST'($urandom | $urandom);
            stage_bus   = {$urandom, 8'($urandom)};
            flush_req   = ($urandom_range(0, 9) == 0);
            flush_stage = 3'($urandom_range(0, 7));
            reset       = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; flush_req = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
